// File: rtl/if_id_inst_queue_if.sv
// if_id_inst_queue_if: fetch-side valid/allowin and decode-side valid/ready channels of the instruction queue
interface if_id_inst_queue_if #(parameter int DATA_W = 64);
  logic in_valid, in_allowin, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_allowin, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_allowin, out_valid, out_data);
endinterface

// File: rtl/if_id_inst_queue.sv
// if_id_inst_queue: fetch-to-decode instruction FIFO with kill; IQ_BYPASS_EN enables empty-queue pass-through
module if_id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 64
) (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic br_taken,
  if_id_inst_queue_if.slave iq,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic kill, empty, push, pop, pass, wr, rd;
  always_comb begin
    kill = flush | br_taken;
    empty = count == '0;
    iq.in_allowin = count != CW'(DEPTH);
    push = iq.in_valid & iq.in_allowin & ~kill;
`ifdef IQ_BYPASS_EN
    iq.out_valid = ~empty | (iq.in_valid & ~kill);
    iq.out_data = empty ? iq.in_data : mem[rptr];
`else
    iq.out_valid = ~empty;
    iq.out_data = mem[rptr];
`endif
    pop = iq.out_valid & iq.out_ready & ~kill;
    // a packet consumed while the queue is empty went straight through and never occupies a slot
    pass = empty & push & pop;
    wr = push & ~pass;
    rd = pop & ~pass;
  end
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !reset) mem[wptr] <= iq.in_data;
  end
endmodule

// File: tb/tb_if_id_inst_queue.sv
// tb_if_id_inst_queue: directed stimulus with a queue-based reference model checked every cycle
module tb_if_id_inst_queue;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, flush = 0, br_taken = 0;
  logic [2:0] count;
  int checks = 0, errors = 0;
  bit armed = 0;
  logic [63:0] mq[$];
  logic [63:0] seen[$];
  if_id_inst_queue_if #(.DATA_W(64)) q();
  if_id_inst_queue #(.DEPTH(DEPTH), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush), .br_taken(br_taken), .iq(q.slave), .count(count)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic bypass_now();
`ifdef IQ_BYPASS_EN
    return mq.size() == 0 && q.in_valid && !flush && !br_taken;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset || flush || br_taken) mq.delete();
    else if (!(bypass_now() && q.out_ready)) begin
      bit acc, pp;
      acc = q.in_valid && mq.size() < DEPTH;
      pp = mq.size() > 0 && q.out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(q.in_data);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic ev;
      ev = mq.size() != 0 || bypass_now();
      check("model_count", 64'(count), 64'(mq.size()));
      check("model_allowin", 64'(q.in_allowin), 64'(mq.size() != DEPTH));
      check("model_valid", 64'(q.out_valid), 64'(ev));
      if (ev) check("model_data", q.out_data, mq.size() != 0 ? mq[0] : q.in_data);
      if (q.out_valid && q.out_ready && !flush && !br_taken && !reset) seen.push_back(q.out_data);
    end
  end

  initial begin
    q.in_valid = 0; q.in_data = '0; q.out_ready = 0;
    repeat (2) step();
    reset = 0;
    armed = 1;
    #1;
    check("rst_count", 64'(count), 0);
    check("rst_allowin", 64'(q.in_allowin), 1);
    check("rst_valid", 64'(q.out_valid), 0);
    q.in_valid = 1; q.in_data = 64'h028000001c000000;
    step();
    q.in_valid = 0;
    #1;
    check("single_valid", 64'(q.out_valid), 1);
    check("single_data", q.out_data, 64'h028000001c000000);
    check("single_count", 64'(count), 1);
    q.out_ready = 1; step(); q.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      q.in_valid = 1; q.in_data = {32'(i), 32'h1c000000 + 32'(4 * i)};
      step();
    end
    q.in_valid = 0; #1;
    check("full_count", 64'(count), 4);
    check("full_allowin", 64'(q.in_allowin), 0);
    q.in_valid = 1; q.in_data = {32'h5, 32'h1c000010};
    step();
    q.in_valid = 0; #1;
    check("full_reject_count", 64'(count), 4);
    check("full_head_pc", 64'(q.out_data[31:0]), 64'h1c000000);
    flush = 1; step(); flush = 0; #1;
    check("flush_count", 64'(count), 0);
    check("flush_allowin", 64'(q.in_allowin), 1);
    q.in_valid = 1; q.in_data = {32'h7, 32'h1c000100};
    step();
    q.in_valid = 0; #1;
    check("flush_head_pc", 64'(q.out_data[31:0]), 64'h1c000100);
    q.out_ready = 1; step(); q.out_ready = 0;
    seen.delete();
    q.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      q.in_valid = 1; q.in_data = {32'h00100000 + 32'(i), 32'h1c001000 + 32'(4 * i)};
      step();
`ifdef IQ_BYPASS_EN
      check("stream_count", 64'(count), 0);
`else
      check("stream_count", 64'(count), 1);
`endif
    end
    q.in_valid = 0;
    repeat (2) step();
    q.out_ready = 0;
    check("stream_len", 64'(seen.size()), 20);
    for (int i = 0; i < 20 && i < seen.size(); i++)
      check("stream_pc", 64'(seen[i][31:0]), 64'(32'h1c001000 + 32'(4 * i)));
    for (int i = 0; i < 3; i++) begin
      q.in_valid = 1; q.in_data = {32'h9, 32'h1c002000 + 32'(4 * i)};
      step();
    end
    seen.delete();
    check("br_pre_count", 64'(count), 3);
    br_taken = 1; q.in_valid = 1; q.in_data = {32'h9, 32'h1c00200c}; q.out_ready = 1;
    step();
    br_taken = 0; q.in_valid = 0; #1;
    check("br_count", 64'(count), 0);
    check("br_valid", 64'(q.out_valid), 0);
    repeat (3) step();
    check("br_seen", 64'(seen.size()), 0);
    q.out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      q.in_valid = 1; q.in_data = {32'ha, 32'h1c004000 + 32'(4 * i)};
      step();
    end
    q.in_valid = 0;
    reset = 1; step(); reset = 0; #1;
    check("midrst_count", 64'(count), 0);
    check("midrst_valid", 64'(q.out_valid), 0);
    q.in_valid = 1; q.in_data = {32'hb, 32'h1c003000}; q.out_ready = 1;
    #1;
`ifdef IQ_BYPASS_EN
    check("byp_valid_now", 64'(q.out_valid), 1);
    check("byp_data_now", q.out_data, {32'hb, 32'h1c003000});
    step();
    q.in_valid = 0; #1;
    check("byp_count", 64'(count), 0);
`else
    check("byp_valid_now", 64'(q.out_valid), 0);
    step();
    q.in_valid = 0; #1;
    check("byp_valid_next", 64'(q.out_valid), 1);
    check("byp_count", 64'(count), 1);
    step();
`endif
    q.out_ready = 0;
    step();
    check("end_count", 64'(count), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
